// File: rtl/yuv_pkg.sv
// Shared definitions for the 4:2:2 timing sequencer: the FSM state encoding
// and the default counter width.
package yuv_pkg;

  // Default width of the size configuration and of the position counters
  localparam int unsigned CNT_W = 12;

  // Frame sequencer phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_BLANK  = 3'd3,
    ST_TRAIL  = 3'd4
  } state_e;

endpackage

// File: rtl/yuv_cfg_check.sv
// Combinational frame-size validation. It is kept in its own module so the
// register block can flag a bad setting before it ever issues a start.
module yuv_cfg_check #(
  parameter int unsigned CNT_W = yuv_pkg::CNT_W
) (
  input  logic [CNT_W-1:0] h_active_i,
  input  logic [CNT_W-1:0] h_blank_i,
  input  logic [CNT_W-1:0] v_active_i,
  output logic             cfg_ok_o
);

  // A line must hold whole U/V pixel pairs, and every interval must be non-empty
  assign cfg_ok_o = !h_active_i[0]
                 && (h_active_i >= CNT_W'(2))
                 && (h_blank_i  != '0)
                 && (v_active_i != '0);

endmodule

// File: rtl/yuv422_timing_ctrl.sv
// Frame/line sequencer for the 4:4:4 -> 4:2:2 packer. One start request runs
// one frame: a FrameValid lead-in, v_active lines of h_active pixels separated
// by h_blank idle cycles, and a FrameValid tail. Every output is a flop.
module yuv422_timing_ctrl #(
  parameter int unsigned CNT_W    = yuv_pkg::CNT_W,
  parameter int unsigned FV_LEAD  = 2,
  parameter int unsigned FV_TRAIL = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] h_active_i,
  input  logic [CNT_W-1:0] h_blank_i,
  input  logic [CNT_W-1:0] v_active_i,
  output logic             FrameValid_o,
  output logic             LineValid_o,
  output logic             uv_sel_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             aborted_o,
  output logic             cfg_err_o
);

  import yuv_pkg::*;

  // Reload values for the phase down-counter (it counts remaining cycles - 1)
  localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'(FV_LEAD - 1);
  localparam logic [CNT_W-1:0] TRAIL_LOAD = CNT_W'(FV_TRAIL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] h_act_q, h_act_d;
  logic [CNT_W-1:0] h_blank_q, h_blank_d;
  logic [CNT_W-1:0] v_act_q, v_act_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic             fv_q, fv_d;
  logic             lv_q, lv_d;
  logic             uv_q, uv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;
  logic             err_q, err_d;
  logic             ab_seen_q, ab_seen_d;

  logic             cfg_ok;
  logic             to_active;
  logic             to_trail;

  yuv_cfg_check #(.CNT_W(CNT_W)) u_cfg_check (
    .h_active_i (h_active_i),
    .h_blank_i  (h_blank_i),
    .v_active_i (v_active_i),
    .cfg_ok_o   (cfg_ok)
  );

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_act_d   = h_act_q;
    h_blank_d = h_blank_q;
    v_act_d   = v_act_q;
    pix_d     = pix_q;
    line_d    = line_q;
    fv_d      = fv_q;
    lv_d      = lv_q;
    uv_d      = uv_q;
    busy_d    = busy_q;
    ab_seen_d = ab_seen_q;
    done_d    = 1'b0;
    abrt_d    = 1'b0;
    err_d     = 1'b0;
    to_active = 1'b0;
    to_trail  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort is meaningless here, so a simultaneous start simply wins
        if (start_i) begin
          if (cfg_ok) begin
            h_act_d   = h_active_i;
            h_blank_d = h_blank_i;
            v_act_d   = v_active_i;
            state_d   = ST_LEAD;
            cnt_d     = LEAD_LOAD;
            fv_d      = 1'b1;
            busy_d    = 1'b1;
            line_d    = '0;
            ab_seen_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LEAD: begin
        if (abort_i) begin
          to_trail  = 1'b1;
          ab_seen_d = 1'b1;
        end else if (cnt_q == '0) begin
          to_active = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ACTIVE: begin
        if (abort_i) begin
          to_trail  = 1'b1;
          ab_seen_d = 1'b1;
        end else if (cnt_q == '0) begin
          // Last line goes straight to the tail without a blank interval
          if (line_q != v_act_q - CNT_W'(1)) begin
            state_d = ST_BLANK;
            cnt_d   = h_blank_q - CNT_W'(1);
            lv_d    = 1'b0;
            pix_d   = '0;
            uv_d    = 1'b0;
          end else begin
            to_trail = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          pix_d = pix_q + CNT_W'(1);
          uv_d  = ~pix_q[0];
        end
      end

      ST_BLANK: begin
        if (abort_i) begin
          to_trail  = 1'b1;
          ab_seen_d = 1'b1;
        end else if (cnt_q == '0) begin
          to_active = 1'b1;
          line_d    = line_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_TRAIL: begin
        // Abort is ignored: the tail always runs its full length
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          fv_d    = 1'b0;
          busy_d  = 1'b0;
          line_d  = '0;
          done_d  = ~ab_seen_q;
          abrt_d  = ab_seen_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Common entry actions shared by several source states
    if (to_active) begin
      state_d = ST_ACTIVE;
      cnt_d   = h_act_q - CNT_W'(1);
      lv_d    = 1'b1;
      pix_d   = '0;
      uv_d    = 1'b0;
    end
    if (to_trail) begin
      state_d = ST_TRAIL;
      cnt_d   = TRAIL_LOAD;
      lv_d    = 1'b0;
      pix_d   = '0;
      uv_d    = 1'b0;
    end
  end

  // State, shadow configuration and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      h_act_q   <= '0;
      h_blank_q <= '0;
      v_act_q   <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      uv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abrt_q    <= 1'b0;
      err_q     <= 1'b0;
      ab_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_act_q   <= h_act_d;
      h_blank_q <= h_blank_d;
      v_act_q   <= v_act_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      fv_q      <= fv_d;
      lv_q      <= lv_d;
      uv_q      <= uv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abrt_q    <= abrt_d;
      err_q     <= err_d;
      ab_seen_q <= ab_seen_d;
    end
  end

  assign FrameValid_o = fv_q;
  assign LineValid_o  = lv_q;
  assign uv_sel_o     = uv_q;
  assign pix_cnt_o    = pix_q;
  assign line_cnt_o   = line_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign aborted_o    = abrt_q;
  assign cfg_err_o    = err_q;

endmodule

// File: tb/tb_yuv422_timing_ctrl.sv
// Bench for the 4:2:2 frame sequencer. For every accepted start the bench
// writes out the full cycle-by-cycle output trace of the frame from the frame
// geometry, and one compare process checks the DUT against it every cycle.
module tb_yuv422_timing_ctrl;

  localparam int CNT_W    = 12;
  localparam int FV_LEAD  = 2;
  localparam int FV_TRAIL = 2;

  typedef struct packed {
    logic             fv;
    logic             lv;
    logic             uv;
    logic [CNT_W-1:0] pix;
    logic [CNT_W-1:0] line;
    logic             busy;
    logic             done;
    logic             abrt;
    logic             err;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] h_active_i;
  logic [CNT_W-1:0] h_blank_i;
  logic [CNT_W-1:0] v_active_i;
  logic             FrameValid_o;
  logic             LineValid_o;
  logic             uv_sel_o;
  logic [CNT_W-1:0] pix_cnt_o;
  logic [CNT_W-1:0] line_cnt_o;
  logic             busy_o;
  logic             frame_done_o;
  logic             aborted_o;
  logic             cfg_err_o;

  exp_t exp_q[$];     // expected outputs, one entry per upcoming cycle
  exp_t last_seq[$];  // trace produced by the most recent model call
  bit   check_en = 1'b0;

  int chk_cmp = 0, err_cmp = 0;  // per-cycle compare process
  int chk_pin = 0, err_pin = 0;  // literal expectations and timeouts

  yuv422_timing_ctrl #(
    .CNT_W    (CNT_W),
    .FV_LEAD  (FV_LEAD),
    .FV_TRAIL (FV_TRAIL)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .h_active_i   (h_active_i),
    .h_blank_i    (h_blank_i),
    .v_active_i   (v_active_i),
    .FrameValid_o (FrameValid_o),
    .LineValid_o  (LineValid_o),
    .uv_sel_o     (uv_sel_o),
    .pix_cnt_o    (pix_cnt_o),
    .line_cnt_o   (line_cnt_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .aborted_o    (aborted_o),
    .cfg_err_o    (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Frame model: entry k is the output seen in the cycle after the edge
  // that sampled start plus k edges. ab > 0 means abort_i is sampled ab edges
  // after the start edge; ab <= 0 means no abort.
  task automatic build_frame(input int h, input int b, input int v, input int ab);
    exp_t seq[$];
    bit   trl[$];
    exp_t e;
    logic [CNT_W-1:0] last_line;
    for (int k = 0; k < FV_LEAD; k++) begin
      e = '0; e.fv = 1'b1; e.busy = 1'b1;
      seq.push_back(e); trl.push_back(1'b0);
    end
    for (int l = 0; l < v; l++) begin
      for (int p = 0; p < h; p++) begin
        e = '0; e.fv = 1'b1; e.busy = 1'b1; e.lv = 1'b1;
        e.pix = CNT_W'(p); e.uv = p[0]; e.line = CNT_W'(l);
        seq.push_back(e); trl.push_back(1'b0);
      end
      if (l < v - 1) begin
        for (int k = 0; k < b; k++) begin
          e = '0; e.fv = 1'b1; e.busy = 1'b1; e.line = CNT_W'(l);
          seq.push_back(e); trl.push_back(1'b0);
        end
      end
    end
    for (int k = 0; k < FV_TRAIL; k++) begin
      e = '0; e.fv = 1'b1; e.busy = 1'b1; e.line = CNT_W'(v - 1);
      seq.push_back(e); trl.push_back(1'b1);
    end
    e = '0; e.done = 1'b1;
    seq.push_back(e); trl.push_back(1'b0);

    // An abort seen before the tail cuts the frame short and gets its own tail
    if (ab > 0 && ab < seq.size() && !trl[ab-1]) begin
      last_line = seq[ab-1].line;
      seq = seq[0:ab-1];
      for (int k = 0; k < FV_TRAIL; k++) begin
        e = '0; e.fv = 1'b1; e.busy = 1'b1; e.line = last_line;
        seq.push_back(e);
      end
      e = '0; e.abrt = 1'b1;
      seq.push_back(e);
    end
    last_seq = seq;
  endtask

  task automatic pin(input string name, input int act, input int req);
    chk_pin++;
    if (act != req) begin
      err_pin++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Single per-cycle comparison against the expected trace (idle = all zero)
  always @(negedge clk_i) begin
    if (check_en) begin
      exp_t act;
      exp_t req;
      act = {FrameValid_o, LineValid_o, uv_sel_o, pix_cnt_o, line_cnt_o,
             busy_o, frame_done_o, aborted_o, cfg_err_o};
      req = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'('0);
      chk_cmp++;
      if (act !== req) begin
        err_cmp++;
        $display("FAIL outputs @%0t: got fv=%b lv=%b uv=%b pix=%0d line=%0d busy=%b done=%b abrt=%b err=%b, expected fv=%b lv=%b uv=%b pix=%0d line=%0d busy=%b done=%b abrt=%b err=%b",
                 $time, act.fv, act.lv, act.uv, act.pix, act.line, act.busy, act.done, act.abrt, act.err,
                 req.fv, req.lv, req.uv, req.pix, req.line, req.busy, req.done, req.abrt, req.err);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk_i); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      err_pin++;
      $display("FAIL frame_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(negedge clk_i); #1;
    end
  endtask

  // One frame: optional abort ab edges after start, optional abort together
  // with start, optional mid-frame config change plus a redundant start.
  task automatic run_frame(input int h, input int b, input int v, input int ab,
                           input bit abort_with_start, input bit poke_mid);
    int cyc;
    @(negedge clk_i); #1;
    h_active_i = CNT_W'(h); h_blank_i = CNT_W'(b); v_active_i = CNT_W'(v);
    start_i = 1'b1; abort_i = abort_with_start;
    build_frame(h, b, v, ab);
    foreach (last_seq[i]) exp_q.push_back(last_seq[i]);
    $display("frame h=%0d b=%0d v=%0d abort_at=%0d trace_len=%0d", h, b, v, ab, last_seq.size());
    @(negedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    cyc = 1;
    if (poke_mid) begin
      repeat (2) begin @(negedge clk_i); #1; end
      h_active_i = 12'd6; h_blank_i = 12'd1; v_active_i = 12'd3;
      start_i = 1'b1;
      @(negedge clk_i); #1;
      start_i = 1'b0;
      cyc += 3;
    end
    if (ab > 0) begin
      while (cyc < ab) begin
        @(negedge clk_i); #1;
        cyc++;
      end
      abort_i = 1'b1;
      @(negedge clk_i); #1;
      abort_i = 1'b0;
    end
    wait_idle();
  endtask

  task automatic bad_start(input int h, input int b, input int v);
    exp_t e;
    @(negedge clk_i); #1;
    h_active_i = CNT_W'(h); h_blank_i = CNT_W'(b); v_active_i = CNT_W'(v);
    start_i = 1'b1;
    e = '0; e.err = 1'b1;
    exp_q.push_back(e);
    $display("bad config h=%0d b=%0d v=%0d", h, b, v);
    @(negedge clk_i); #1;
    start_i = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    h_active_i = '0; h_blank_i = '0; v_active_i = '0;

    // Literal expectations for the model itself: 4x2 frame, blank 2
    build_frame(4, 2, 2, 0);
    pin("m1_len", last_seq.size(), 15);
    pin("m1_fv_n1", last_seq[0].fv, 1);
    pin("m1_lv_n2", last_seq[1].lv, 0);
    pin("m1_lv_n3", last_seq[2].lv, 1);
    pin("m1_lv_n6", last_seq[5].lv, 1);
    pin("m1_lv_n7", last_seq[6].lv, 0);
    pin("m1_lv_n9", last_seq[8].lv, 1);
    pin("m1_lv_n13", last_seq[12].lv, 0);
    pin("m1_fv_n14", last_seq[13].fv, 1);
    pin("m1_fv_n15", last_seq[14].fv, 0);
    pin("m1_done_n15", last_seq[14].done, 1);
    pin("m1_uv_line0", {last_seq[2].uv, last_seq[3].uv, last_seq[4].uv, last_seq[5].uv}, 4'b0101);
    pin("m1_pix_n6", last_seq[5].pix, 3);
    pin("m1_uv_line1", last_seq[8].uv, 0);
    pin("m1_line_n9", last_seq[8].line, 1);
    // Abort sampled on the 2nd pixel of the first line
    build_frame(4, 2, 2, 4);
    pin("m4_len", last_seq.size(), 7);
    pin("m4_lv_after", last_seq[4].lv, 0);
    pin("m4_fv_trail", last_seq[5].fv, 1);
    pin("m4_aborted", last_seq[6].abrt, 1);
    pin("m4_done", last_seq[6].done, 0);
    last_seq.delete();

    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    check_en = 1'b1;
    @(negedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) begin @(negedge clk_i); #1; end

    run_frame(4, 2, 2, 0, 1'b0, 1'b0);   // basic frame, U/V phase per line
    bad_start(3, 2, 2);                  // odd width
    bad_start(4, 0, 2);                  // no blank
    bad_start(4, 2, 0);                  // no lines
    bad_start(0, 2, 1);                  // zero width
    run_frame(4, 2, 2, 4, 1'b0, 1'b0);   // abort mid-line
    run_frame(4, 2, 2, 1, 1'b0, 1'b0);   // abort in lead-in
    run_frame(4, 2, 2, 7, 1'b0, 1'b0);   // abort in blank
    run_frame(4, 2, 2, 12, 1'b0, 1'b0);  // abort on final pixel
    run_frame(4, 2, 2, 13, 1'b0, 1'b0);  // abort in tail: ignored
    run_frame(4, 2, 2, 0, 1'b1, 1'b0);   // start and abort together
    run_frame(4, 3, 2, 0, 1'b0, 1'b1);   // config changes and restart mid-frame
    run_frame(2, 1, 1, 0, 1'b0, 1'b0);   // minimum geometry
    run_frame(2, 1, 3, 0, 1'b0, 1'b0);
    run_frame(4094, 1, 1, 0, 1'b0, 1'b0);// widest line

    // Reset in the middle of an active line, then a clean frame
    @(negedge clk_i); #1;
    h_active_i = 12'd6; h_blank_i = 12'd2; v_active_i = 12'd3;
    start_i = 1'b1;
    build_frame(6, 2, 3, 0);
    foreach (last_seq[i]) exp_q.push_back(last_seq[i]);
    $display("frame h=6 b=2 v=3 with reset during active");
    @(negedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) begin @(negedge clk_i); #1; end
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) begin @(negedge clk_i); #1; end
    run_frame(6, 2, 3, 0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", chk_cmp + chk_pin, err_cmp + err_pin);
    $finish;
  end

endmodule
